ex_divider: RTL and testbench
=============================

EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  in  1  asynchronous reset, active-low (0 = asserted).
REQ-003 SHALL have port flush  in  1  pipeline flush, aborts any divide in progress.
REQ-004 SHALL have port stall  in  1  downstream stall that holds the EX stage.
REQ-005 SHALL have port ex_aluop  in  ALUOp width  EX-stage operation code from the ID/EX register.
REQ-006 SHALL have port ex_opr1  in  32  dividend.
REQ-007 SHALL have port ex_opr2  in  32  divisor.
REQ-008 SHALL have port div_stallreq  out  1  request to stall IF..EX while the divide is unfinished.
REQ-009 SHALL have port div_valid  out  1  result valid, high only in DONE.
REQ-010 SHALL have port div_hi  out  32  remainder (HI).
REQ-011 SHALL have port div_lo  out  32  quotient (LO).

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 IDLE: when ex_aluop is ALU_DIV or ALU_DIVU and flush=0, SHALL capture the operands and go to BUSY on the next edge.
REQ-014 div_stallreq SHALL be high combinationally in IDLE when a divide op is present and flush=0, and SHALL stay high throughout BUSY.
REQ-015 BUSY SHALL run exactly 32 restoring-division iterations (5-bit counter 0..31), one per cycle, then go to DONE.
REQ-016 DONE: div_valid=1 and div_stallreq=0; the block SHALL go to IDLE on the next edge when stall=0 and SHALL hold DONE with results stable while stall=1.
REQ-017 Fixed latency: divide presented in cycle 0, div_valid in cycle 33, unless REQ-024 applies.
REQ-018 ALU_DIVU: unsigned operands; ALU_DIV: SHALL divide magnitudes, negate the quotient when operand signs differ, and give the remainder the sign of the dividend.
REQ-019 0x80000000 / 0xFFFFFFFF (signed) SHALL give lo=0x80000000 and hi=0.
REQ-020 flush=1 in any state SHALL force IDLE on the next edge with div_valid=0 and div_stallreq=0; the partial result is discarded.
REQ-021 A divide presented in the cycle after DONE SHALL start normally, so back-to-back divides each take full latency.
REQ-022 Non-divide ops in IDLE SHALL leave the state unchanged and div_stallreq=0.

Reset
REQ-023 While rst=0: state=IDLE, counter=0, div_hi=0, div_lo=0, div_valid=0, div_stallreq=0; an in-flight divide is discarded.

Configuration
REQ-024 With macro DIV_ZERO_FAST_EN defined, divisor 0 SHALL go from IDLE directly to DONE: div_valid in cycle 1, hi=ex_opr1, lo=0xFFFFFFFF, signed or unsigned.
REQ-025 Without DIV_ZERO_FAST_EN, divisor 0 SHALL take the full 32-iteration path with 33-cycle latency; result values are architecturally unpredictable and only the timing is checked.

Structure
REQ-026 ALU_DIV/ALU_DIVU codes, the ALUOp width, and the state encodings (DIV_IDLE, DIV_BUSY, DIV_DONE) SHALL live in the shared defines package.
REQ-027 One sub-module, div_iter, SHALL implement a single combinational restoring step (remainder/quotient shift-subtract); ex_divider holds the FSM, counter, and sign fixup.

Verification
REQ-028 DIVU 100/7 -> stallreq high for cycles 0..32, div_valid in cycle 33, lo=14, hi=2.
REQ-029 DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 -> lo=-3, hi=1.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, no hang.
REQ-031 flush at BUSY counter=10 -> IDLE next cycle, stallreq=0, then a following DIVU 9/3 -> lo=3, hi=0 with full latency.
REQ-032 stall=1 for 3 cycles while in DONE -> div_valid held 4 cycles with stable hi/lo; rst pulsed low mid-BUSY -> all outputs 0 immediately.
REQ-033 DIVU 5/0 with DIV_ZERO_FAST_EN -> div_valid in cycle 1, hi=5, lo=0xFFFFFFFF; without it -> div_valid in cycle 33.

Source files
------------

// File: rtl/ex_divider_pkg.sv
// Shared defines for the EX-stage divider: ALU opcodes, divider FSM encodings,
// and small helpers used by the divider datapath.
package ex_divider_pkg;

   localparam int ALUOP_W = 8;

   typedef logic [ALUOP_W-1:0] aluop_t;

   localparam aluop_t ALU_NOP  = 8'h00;
   localparam aluop_t ALU_DIV  = 8'h1A;
   localparam aluop_t ALU_DIVU = 8'h1B;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input aluop_t op);
      return (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

   // Magnitude of a two's-complement word; 0x80000000 maps to itself, which is
   // exactly the unsigned magnitude the restoring loop needs.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_divider_if.sv
// EX-stage to divider bus: operation/operands in, stall request and results out.
interface ex_divider_if;
   import ex_divider_pkg::*;

   aluop_t      ex_aluop;
   logic [31:0] ex_opr1;
   logic [31:0] ex_opr2;
   logic        div_stallreq;
   logic        div_valid;
   logic [31:0] div_hi;
   logic [31:0] div_lo;

   modport master (
      output ex_aluop, ex_opr1, ex_opr2,
      input  div_stallreq, div_valid, div_hi, div_lo
   );

   modport slave (
      input  ex_aluop, ex_opr1, ex_opr2,
      output div_stallreq, div_valid, div_hi, div_lo
   );

endinterface

// File: rtl/ex_divider_div_iter.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, try a subtract, and shift the resulting quotient bit in.
module div_iter (
   input  logic [31:0] rem_in,
   input  logic [31:0] quo_in,
   input  logic [31:0] divisor,
   output logic [31:0] rem_out,
   output logic [31:0] quo_out
);

   logic [32:0] shifted;
   logic [32:0] diff;

   // A borrow out of the 33-bit subtract means the trial failed and the
   // shifted remainder is restored.
   always_comb begin
      shifted = {rem_in, quo_in[31]};
      diff    = shifted - {1'b0, divisor};
      quo_out = {quo_in[30:0], ~diff[32]};
      rem_out = diff[32] ? shifted[31:0] : diff[31:0];
   end

endmodule

// File: rtl/ex_divider.sv
// Multi-cycle EX-stage divider (32 restoring iterations, signed/unsigned).
// Optional macro DIV_ZERO_FAST_EN: divisor 0 completes in one cycle with hi=dividend, lo=all ones.
module ex_divider
   import ex_divider_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         stall,
   ex_divider_if.slave  bus
);

   div_state_e  state_q;
   div_state_e  state_d;
   logic [4:0]  cnt_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        neg_quo_q;
   logic        neg_rem_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        signed_op;
   logic        start;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [31:0] rem_nx;
   logic [31:0] quo_nx;
   logic [31:0] hi_fix;
   logic [31:0] lo_fix;
   logic        last_iter;

   div_iter u_iter (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dvs_q),
      .rem_out (rem_nx),
      .quo_out (quo_nx)
   );

   // The loop always works on magnitudes; signs are reapplied on the final step.
   always_comb begin
      signed_op = (bus.ex_aluop == ALU_DIV);
      start     = is_div_op(bus.ex_aluop) && !flush;
      mag1      = signed_op ? abs32(bus.ex_opr1) : bus.ex_opr1;
      mag2      = signed_op ? abs32(bus.ex_opr2) : bus.ex_opr2;
      last_iter = (cnt_q == 5'd31);
      lo_fix    = neg_quo_q ? (~quo_nx + 32'd1) : quo_nx;
      hi_fix    = neg_rem_q ? (~rem_nx + 32'd1) : rem_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush overrides every other transition so a squashed divide never surfaces.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_IDLE: begin
`ifdef DIV_ZERO_FAST_EN
            if (start) state_d = (bus.ex_opr2 == 32'd0) ? DIV_DONE : DIV_BUSY;
`else
            if (start) state_d = DIV_BUSY;
`endif
         end
         DIV_BUSY: begin
            if (last_iter) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            if (!stall) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (flush) state_d = DIV_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= 5'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_q     <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (start) begin
                  cnt_q     <= 5'd0;
                  rem_q     <= 32'd0;
                  quo_q     <= mag1;
                  dvs_q     <= mag2;
                  neg_quo_q <= signed_op && (bus.ex_opr1[31] ^ bus.ex_opr2[31]);
                  neg_rem_q <= signed_op && bus.ex_opr1[31];
`ifdef DIV_ZERO_FAST_EN
                  if (bus.ex_opr2 == 32'd0) begin
                     hi_q <= bus.ex_opr1;
                     lo_q <= 32'hFFFF_FFFF;
                  end
`endif
               end
            end
            DIV_BUSY: begin
               if (flush) begin
                  cnt_q <= 5'd0;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt_q <= cnt_q + 5'd1;
                  if (last_iter) begin
                     hi_q <= hi_fix;
                     lo_q <= lo_fix;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Stall request is gated by reset so the pipeline is released immediately.
   always_comb begin
      bus.div_stallreq = rst && (((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY));
      bus.div_valid    = (state_q == DIV_DONE);
      bus.div_hi       = hi_q;
      bus.div_lo       = lo_q;
   end

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed literal cases plus a randomized
// run compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_ex_divider;
   import ex_divider_pkg::*;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;
   logic stall = 1'b0;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   ex_divider_if bus ();

   ex_divider dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .stall (stall),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: cycles until a result appears, and whether one is shown.
   int          m_left = 0;
   bit          m_show = 1'b0;
   bit          m_care = 1'b1;
   bit          p_care = 1'b1;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        exp_stall;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                                input logic fl, input logic st);
      bus.ex_aluop = op;
      bus.ex_opr1  = a;
      bus.ex_opr2  = b;
      flush        = fl;
      stall        = st;
   endtask

   function automatic void ref_div(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit care);
      longint sa, sb, q, r;
      care = 1'b1;
      hi   = '0;
      lo   = '0;
      if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
`ifndef DIV_ZERO_FAST_EN
         care = 1'b0;
`endif
      end else if (op == ALU_DIVU) begin
         lo = a / b;
         hi = a % b;
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         q  = sa / sb;
         r  = sa % sb;
         lo = q[31:0];
         hi = r[31:0];
      end
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left = 0;
         m_show = 1'b0;
         m_care = 1'b1;
         m_hi   = '0;
         m_lo   = '0;
      end else if (flush) begin
         m_left = 0;
         m_show = 1'b0;
      end else if (m_show) begin
         if (!stall) m_show = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_show = 1'b1;
            m_hi   = p_hi;
            m_lo   = p_lo;
            m_care = p_care;
         end
      end else if (is_div_op(bus.ex_aluop)) begin
         ref_div(bus.ex_aluop, bus.ex_opr1, bus.ex_opr2, p_hi, p_lo, p_care);
`ifdef DIV_ZERO_FAST_EN
         if (bus.ex_opr2 == 32'd0) begin
            m_show = 1'b1;
            m_hi   = p_hi;
            m_lo   = p_lo;
            m_care = p_care;
         end else begin
            m_left = 32;
         end
`else
         m_left = 32;
`endif
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         exp_stall = rst && ((m_left > 0) || (!m_show && is_div_op(bus.ex_aluop) && !flush));
         checkOutput("valid", {31'd0, bus.div_valid}, {31'd0, m_show});
         checkOutput("stallreq", {31'd0, bus.div_stallreq}, {31'd0, exp_stall});
         if (m_show && m_care) begin
            checkOutput("model_hi", bus.div_hi, m_hi);
            checkOutput("model_lo", bus.div_lo, m_lo);
         end
      end
   end

   // Presents one divide for a single cycle and returns the cycle index of div_valid.
   task automatic issueAndWait(input aluop_t op, input logic [31:0] a, input logic [31:0] b, output int lat);
      @(posedge clk); #1;
      applyStimulus(op, a, b, 1'b0, 1'b0);
      lat = -1;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (bus.div_valid) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
         applyStimulus(ALU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int exp_lat;
      logic [31:0] held_hi, held_lo;

      applyStimulus(ALU_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", {31'd0, bus.div_valid}, 32'd0);
      checkOutput("reset_stallreq", {31'd0, bus.div_stallreq}, 32'd0);
      checkOutput("reset_hi", bus.div_hi, 32'd0);
      checkOutput("reset_lo", bus.div_lo, 32'd0);
      applyStimulus(ALU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      rst    = 1'b1;
      cmp_en = 1'b1;

      issueAndWait(ALU_DIVU, 32'd100, 32'd7, lat);
      checkOutput("divu_100_7_lat", lat, 32'd33);
      checkOutput("divu_100_7_lo", bus.div_lo, 32'd14);
      checkOutput("divu_100_7_hi", bus.div_hi, 32'd2);

      issueAndWait(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat);
      checkOutput("div_m7_2_lat", lat, 32'd33);
      checkOutput("div_m7_2_lo", bus.div_lo, 32'hFFFF_FFFD);
      checkOutput("div_m7_2_hi", bus.div_hi, 32'hFFFF_FFFF);

      issueAndWait(ALU_DIV, 32'd7, 32'hFFFF_FFFE, lat);
      checkOutput("div_7_m2_lo", bus.div_lo, 32'hFFFF_FFFD);
      checkOutput("div_7_m2_hi", bus.div_hi, 32'd1);

      issueAndWait(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      checkOutput("div_ovf_lat", lat, 32'd33);
      checkOutput("div_ovf_lo", bus.div_lo, 32'h8000_0000);
      checkOutput("div_ovf_hi", bus.div_hi, 32'd0);

      issueAndWait(ALU_DIVU, 32'd1000, 32'd10, lat);
      checkOutput("stall_lat", lat, 32'd33);
      stall   = 1'b1;
      held_hi = bus.div_hi;
      held_lo = bus.div_lo;
      checkOutput("stall_lo", held_lo, 32'd100);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k == 2) stall = 1'b0;
         @(negedge clk);
         checkOutput("stall_hold_valid", {31'd0, bus.div_valid}, 32'd1);
         checkOutput("stall_hold_hi", bus.div_hi, held_hi);
         checkOutput("stall_hold_lo", bus.div_lo, held_lo);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("stall_release_valid", {31'd0, bus.div_valid}, 32'd0);

      @(posedge clk); #1;
      applyStimulus(ALU_DIVU, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         applyStimulus(ALU_NOP, 32'd0, 32'd0, (c == 11), 1'b0);
      end
      @(posedge clk); #1;
      applyStimulus(ALU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush_valid", {31'd0, bus.div_valid}, 32'd0);
      checkOutput("flush_stallreq", {31'd0, bus.div_stallreq}, 32'd0);
      issueAndWait(ALU_DIVU, 32'd9, 32'd3, lat);
      checkOutput("after_flush_lat", lat, 32'd33);
      checkOutput("after_flush_lo", bus.div_lo, 32'd3);
      checkOutput("after_flush_hi", bus.div_hi, 32'd0);

`ifdef DIV_ZERO_FAST_EN
      exp_lat = 1;
`else
      exp_lat = 33;
`endif
      issueAndWait(ALU_DIVU, 32'd5, 32'd0, lat);
      checkOutput("divzero_lat", lat, exp_lat);
`ifdef DIV_ZERO_FAST_EN
      checkOutput("divzero_hi", bus.div_hi, 32'd5);
      checkOutput("divzero_lo", bus.div_lo, 32'hFFFF_FFFF);
`endif

      issueAndWait(ALU_DIVU, 32'd77, 32'd4, lat);
      checkOutput("pre_reset_lo", bus.div_lo, 32'd19);
      @(posedge clk); #1;
      applyStimulus(ALU_DIVU, 32'd50, 32'd5, 1'b0, 1'b0);
      repeat (6) begin
         @(posedge clk); #1;
         applyStimulus(ALU_DIVU, 32'd50, 32'd5, 1'b0, 1'b0);
      end
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midreset_valid", {31'd0, bus.div_valid}, 32'd0);
      checkOutput("midreset_stallreq", {31'd0, bus.div_stallreq}, 32'd0);
      checkOutput("midreset_hi", bus.div_hi, 32'd0);
      checkOutput("midreset_lo", bus.div_lo, 32'd0);
      @(posedge clk); #1;
      applyStimulus(ALU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < 2500; i++) begin
         logic [31:0] a, b;
         aluop_t      op;
         int          r;
         @(posedge clk); #1;
         r  = $urandom_range(0, 9);
         op = (r < 2) ? ALU_DIV : (r < 4) ? ALU_DIVU : ((r < 7) ? ALU_NOP : aluop_t'(8'h21));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'h8000_0000;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'd0;
            3: b = $urandom_range(1, 17);
            4: a = $urandom_range(0, 100);
            default: ;
         endcase
         if ($urandom_range(0, 4) == 0) b = {{16{b[15]}}, b[15:0]};
         applyStimulus(op, a, b, ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1);
      end
      @(posedge clk); #1;
      applyStimulus(ALU_NOP, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
